boot_loader: RTL and testbench

BOOT_LOADER -- requirements
Module: boot_loader

---
 rtl/boot_loader.sv | 189 ++++++++++++++++++
 tb/tb_boot_loader.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/boot_loader.sv
// Boot loader: receives a byte-stream program image (word count, hi/lo data
// byte pairs, XOR checksum), writes each 16-bit word into instruction memory
// and launches the CPU only when the checksum matches.
// Ports:
//   clock, reset             - system clock, asynchronous active-high reset
//   load                     - level request to start a load session
//   rx_data/rx_valid/rx_ready - byte stream handshake (transfer on valid&ready)
//   im_addr/im_data/im_we    - instruction-memory write port
//   cpu_start/cpu_enable     - one-cycle launch pulse / run enable level
//   busy/error               - session in progress / session failed
module boot_loader #(
  parameter logic [7:0]  BASE_ADDR = 8'h00,
  parameter int unsigned TIMEOUT   = 50000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  im_addr,
  output logic [15:0] im_data,
  output logic        im_we,
  output logic        cpu_start,
  output logic        cpu_enable,
  output logic        busy,
  output logic        error
);

  localparam int unsigned TW = 16;

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_HDR   = 4'd1;
  localparam logic [3:0] S_HI    = 4'd2;
  localparam logic [3:0] S_LO    = 4'd3;
  localparam logic [3:0] S_WRITE = 4'd4;
  localparam logic [3:0] S_CSUM  = 4'd5;
  localparam logic [3:0] S_START = 4'd6;
  localparam logic [3:0] S_DONE  = 4'd7;
  localparam logic [3:0] S_ERROR = 4'd8;

  logic [3:0]    state, state_d;
  logic [7:0]    count, count_d;
  logic [7:0]    index, index_d;
  logic [7:0]    csum, csum_d;
  logic [7:0]    hi_byte, hi_byte_d;
  logic [TW-1:0] tcnt, tcnt_d;
  logic [7:0]    im_addr_d;
  logic [15:0]   im_data_d;
  logic          cpu_enable_d;
  logic          rx_ready_d, im_we_d, cpu_start_d, busy_d, error_d;

  logic          accept;
  logic [TW-1:0] tick;
  logic          timed_out;
  logic [7:0]    index_inc;

  assign accept    = rx_valid & rx_ready;
  assign tick      = tcnt + TW'(1);
  assign timed_out = (tick == TW'(TIMEOUT));
  assign index_inc = index + 8'd1;

  // State register; every output is registered from its next-state value.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      count      <= '0;
      index      <= '0;
      csum       <= '0;
      hi_byte    <= '0;
      tcnt       <= '0;
      im_addr    <= '0;
      im_data    <= '0;
      im_we      <= 1'b0;
      cpu_start  <= 1'b0;
      cpu_enable <= 1'b0;
      rx_ready   <= 1'b0;
      busy       <= 1'b0;
      error      <= 1'b0;
    end else begin
      state      <= state_d;
      count      <= count_d;
      index      <= index_d;
      csum       <= csum_d;
      hi_byte    <= hi_byte_d;
      tcnt       <= tcnt_d;
      im_addr    <= im_addr_d;
      im_data    <= im_data_d;
      im_we      <= im_we_d;
      cpu_start  <= cpu_start_d;
      cpu_enable <= cpu_enable_d;
      rx_ready   <= rx_ready_d;
      busy       <= busy_d;
      error      <= error_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state;
    count_d      = count;
    index_d      = index;
    csum_d       = csum;
    hi_byte_d    = hi_byte;
    tcnt_d       = tcnt;
    im_addr_d    = im_addr;
    im_data_d    = im_data;
    cpu_enable_d = cpu_enable;

    case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (load) begin
          state_d      = S_HDR;
          index_d      = '0;
          csum_d       = '0;
          tcnt_d       = '0;
          cpu_enable_d = 1'b0;
        end
      end
      S_HDR: begin
        if (accept) begin
          count_d = rx_data;
          csum_d  = csum ^ rx_data;
          tcnt_d  = '0;
          state_d = (rx_data == 8'd0) ? S_CSUM : S_HI;
        end else if (timed_out) begin
          state_d = S_ERROR;
        end else begin
          tcnt_d = tick;
        end
      end
      S_HI: begin
        if (accept) begin
          hi_byte_d = rx_data;
          csum_d    = csum ^ rx_data;
          tcnt_d    = '0;
          state_d   = S_LO;
        end else if (timed_out) begin
          state_d = S_ERROR;
        end else begin
          tcnt_d = tick;
        end
      end
      S_LO: begin
        // Address and data change together on entry to WRITE so that they
        // hold their previous values everywhere else.
        if (accept) begin
          im_data_d = {hi_byte, rx_data};
          im_addr_d = BASE_ADDR + index;
          csum_d    = csum ^ rx_data;
          tcnt_d    = '0;
          state_d   = S_WRITE;
        end else if (timed_out) begin
          state_d = S_ERROR;
        end else begin
          tcnt_d = tick;
        end
      end
      S_WRITE: begin
        index_d = index_inc;
        state_d = (index_inc == count) ? S_CSUM : S_HI;
      end
      S_CSUM: begin
        if (accept) begin
          tcnt_d  = '0;
          state_d = (rx_data == csum) ? S_START : S_ERROR;
        end else if (timed_out) begin
          state_d = S_ERROR;
        end else begin
          tcnt_d = tick;
        end
      end
      S_START: begin
        state_d      = S_DONE;
        cpu_enable_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    rx_ready_d  = (state_d == S_HDR) || (state_d == S_HI) ||
                  (state_d == S_LO)  || (state_d == S_CSUM);
    im_we_d     = (state_d == S_WRITE);
    cpu_start_d = (state_d == S_START);
    busy_d      = !((state_d == S_IDLE) || (state_d == S_DONE) ||
                    (state_d == S_ERROR));
    error_d     = (state_d == S_ERROR);
  end

endmodule

// File: tb/tb_boot_loader.sv
// Bench for boot_loader: two instances (base 0x00 and 0xFF, timeout 10) share
// one randomized byte stream; a reference model queues the expected writes
// and session outcome, and negedge monitors score the DUT outputs.
module tb_boot_loader;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       load = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;

  logic        rx_ready_a, im_we_a, cpu_start_a, cpu_enable_a, busy_a, error_a;
  logic [7:0]  im_addr_a;
  logic [15:0] im_data_a;
  logic        rx_ready_b, im_we_b, cpu_start_b, cpu_enable_b, busy_b, error_b;
  logic [7:0]  im_addr_b;
  logic [15:0] im_data_b;

  always #5 clock = ~clock;

  boot_loader #(.BASE_ADDR(8'h00), .TIMEOUT(10)) dut_a (
    .clock(clock), .reset(reset), .load(load), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready_a), .im_addr(im_addr_a),
    .im_data(im_data_a), .im_we(im_we_a), .cpu_start(cpu_start_a),
    .cpu_enable(cpu_enable_a), .busy(busy_a), .error(error_a)
  );

  boot_loader #(.BASE_ADDR(8'hFF), .TIMEOUT(10)) dut_b (
    .clock(clock), .reset(reset), .load(load), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready_b), .im_addr(im_addr_b),
    .im_data(im_data_b), .im_we(im_we_b), .cpu_start(cpu_start_b),
    .cpu_enable(cpu_enable_b), .busy(busy_b), .error(error_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Expected writes as {addr, data}.
  logic [23:0] qa[$];
  logic [23:0] qb[$];
  logic [23:0] ea, eb;
  int starts_a = 0;
  int starts_b = 0;

  logic [15:0] words[256];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitors.
  always @(negedge clock) begin
    if (!reset) begin
      if (im_we_a) begin
        check("write_a_expected", 32'(qa.size() != 0), 32'd1);
        if (qa.size() != 0) begin
          ea = qa.pop_front();
          check("write_a", {8'h00, im_addr_a, im_data_a}, {8'h00, ea});
        end
      end
      if (im_we_b) begin
        check("write_b_expected", 32'(qb.size() != 0), 32'd1);
        if (qb.size() != 0) begin
          eb = qb.pop_front();
          check("write_b", {8'h00, im_addr_b, im_data_b}, {8'h00, eb});
        end
      end
      if (cpu_start_a) starts_a++;
      if (cpu_start_b) starts_b++;
    end
  end

  // Reference: checksum is the XOR of the header and every data byte.
  function automatic logic [7:0] stream_xor(input int n);
    logic [7:0] s;
    s = 8'(n);
    for (int i = 0; i < n; i++) s = s ^ words[i][15:8] ^ words[i][7:0];
    return s;
  endfunction

  // Present one byte after a random gap and hold it until accepted.
  task automatic send_byte(input logic [7:0] b);
    int waitc;
    repeat ($urandom_range(0, 3)) begin
      @(posedge clock); #1;
    end
    rx_data  = b;
    rx_valid = 1'b1;
    waitc    = 0;
    forever begin
      @(negedge clock);
      if (rx_ready_a && rx_ready_b) break;
      waitc++;
      if (waitc > 30) break;
    end
    check("byte_accept_bound", 32'(waitc <= 30), 32'd1);
    @(posedge clock); #1;
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic do_load();
    load = 1'b1;
    @(posedge clock); #1;
    load = 1'b0;
  endtask

  task automatic run_session(input int n, input logic [7:0] csum_sent, input logic noise);
    logic ok;
    int   c;
    ok = (csum_sent == stream_xor(n));
    starts_a = 0;
    starts_b = 0;
    for (int i = 0; i < n; i++) begin
      qa.push_back({8'((0 + i) % 256), words[i]});
      qb.push_back({8'((255 + i) % 256), words[i]});
    end
    do_load();
    send_byte(8'(n));
    for (int i = 0; i < n; i++) begin
      load = noise ? 1'($urandom) : 1'b0;
      send_byte(words[i][15:8]);
      load = noise ? 1'($urandom) : 1'b0;
      send_byte(words[i][7:0]);
    end
    load = 1'b0;
    send_byte(csum_sent);
    c = 0;
    while (busy_a && c < 20) begin
      @(posedge clock); #1;
      c++;
    end
    check("session_end", 32'(busy_a), 32'd0);
    repeat (2) begin
      @(posedge clock); #1;
    end
    check("error_a", 32'(error_a), 32'(!ok));
    check("cpu_enable_a", 32'(cpu_enable_a), 32'(ok));
    check("starts_a", 32'(starts_a), ok ? 32'd1 : 32'd0);
    check("pending_writes_a", 32'(qa.size()), 32'd0);
    check("error_b", 32'(error_b), 32'(!ok));
    check("cpu_enable_b", 32'(cpu_enable_b), 32'(ok));
    check("starts_b", 32'(starts_b), ok ? 32'd1 : 32'd0);
    check("pending_writes_b", 32'(qb.size()), 32'd0);
    qa.delete();
    qb.delete();
  endtask

  initial begin
    int n;
    int cyc;
    logic [7:0] cs;

    #2 reset = 1'b1;
    #1;
    check("reset_outputs_a", {2'b0, rx_ready_a, im_we_a, cpu_start_a, cpu_enable_a,
          busy_a, error_a, im_addr_a, im_data_a}, 32'd0);
    check("reset_outputs_b", {2'b0, rx_ready_b, im_we_b, cpu_start_b, cpu_enable_b,
          busy_b, error_b, im_addr_b, im_data_b}, 32'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    repeat (2) begin
      @(posedge clock); #1;
    end

    // Directed stream 02,12,34,AB,CD: XOR of the stream is 0x42.
    words[0] = 16'h1234;
    words[1] = 16'hABCD;
    run_session(2, 8'h42, 1'b0);
    run_session(2, 8'h41, 1'b0);
    // Empty program.
    run_session(0, 8'h00, 1'b0);

    // Randomized sessions with load noise while busy.
    for (int s = 0; s < 10; s++) begin
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) words[i] = 16'($urandom);
      cs = stream_xor(n);
      if ($urandom_range(0, 3) == 0) cs = cs ^ (8'h01 << $urandom_range(0, 7));
      run_session(n, cs, 1'b1);
    end

    // Stream stalls after the first HI byte.
    starts_a = 0;
    do_load();
    send_byte(8'd2);
    send_byte(8'h5A);
    cyc = 0;
    while (!error_a && cyc < 40) begin
      @(posedge clock); #1;
      cyc++;
    end
    check("timeout_cycles", 32'(cyc), 32'd10);
    check("timeout_error_b", 32'(error_b), 32'd1);
    check("timeout_cpu_enable", 32'(cpu_enable_a), 32'd0);
    check("timeout_starts", 32'(starts_a), 32'd0);

    // Reset between HI and LO bytes.
    do_load();
    send_byte(8'd2);
    send_byte(8'h77);
    @(posedge clock);
    #3 reset = 1'b1;
    #1;
    check("midreset_outputs_a", {2'b0, rx_ready_a, im_we_a, cpu_start_a, cpu_enable_a,
          busy_a, error_a, im_addr_a, im_data_a}, 32'd0);
    check("midreset_outputs_b", {2'b0, rx_ready_b, im_we_b, cpu_start_b, cpu_enable_b,
          busy_b, error_b, im_addr_b, im_data_b}, 32'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    rx_data  = 8'h33;
    rx_valid = 1'b1;
    repeat (8) begin
      @(posedge clock); #1;
    end
    rx_valid = 1'b0;
    check("post_reset_idle", {30'd0, busy_a, rx_ready_a}, 32'd0);
    words[0] = 16'hBEEF;
    words[1] = 16'h0102;
    run_session(2, stream_xor(2), 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
